// File: rtl/ram_ctrl_if.sv
// Request/response bundle between a core and ram_ctrl.
// The core drives requests; the controller drives ready and responses.
interface ram_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ram_ctrl.sv
// Single-port synchronous RAM with byte enables, pipelined reads,
// range checking and an optional zero-fill sweep after reset.
module ram_ctrl #(
    parameter int    DATA_W         = 16,
    parameter int    ADDR_W         = 16,
    parameter int    DEPTH          = 512,
    parameter int    RD_LAT         = 1,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = ""
) (
    input  logic      clk,
    input  logic      rst_n,
    ram_ctrl_if.slave bus,
    output logic      wr_err,
    output logic      busy
);
    localparam int NB = DATA_W / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [IW-1:0]   LAST    = IW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0]     clear_cnt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] s0_data;
    logic [DATA_W-1:0] out_data;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] err_q;
    logic              in_range;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic              clr_we;

    // Full-width compare: addresses past DEPTH never alias onto real words.
    assign in_range = {1'b0, bus.req_addr} < DEPTH_W;
    assign idx      = bus.req_addr[IW-1:0];
    assign acc      = rst_n && (state_q == ST_RUN) && bus.req_valid;
    assign wr_acc   = acc && bus.req_we;
    assign rd_acc   = acc && !bus.req_we;
    assign clr_we   = rst_n && (state_q == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        bus.req_ready = 1'b0;
        unique case (state_q)
            ST_RESET: state_d = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            ST_CLEAR: begin
                busy = 1'b1;
                if (clear_cnt == LAST) state_d = ST_RUN;
            end
            ST_RUN:   bus.req_ready = 1'b1;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clear_cnt <= '0;
            wr_err    <= 1'b0;
            vld_q     <= '0;
            err_q     <= '0;
        end else begin
            if (state_q == ST_CLEAR) clear_cnt <= clear_cnt + 1'b1;
            if (wr_acc && !in_range) wr_err <= 1'b1;
            vld_q[0] <= rd_acc;
            err_q[0] <= rd_acc && !in_range;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                err_q[k] <= err_q[k-1];
            end
        end
    end

    // Array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clear_cnt] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_be[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
        if (rd_acc) ram_q <= mem[idx];
    end

    assign s0_data = (vld_q[0] && !err_q[0]) ? ram_q : '0;

    if (RD_LAT > 1) begin : g_pipe
        logic [DATA_W-1:0] dq [RD_LAT-1];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int k = 0; k < RD_LAT-1; k++) dq[k] <= '0;
            end else begin
                dq[0] <= s0_data;
                for (int k = 1; k < RD_LAT-1; k++) dq[k] <= dq[k-1];
            end
        end
        assign out_data = dq[RD_LAT-2];
    end else begin : g_nopipe
        assign out_data = s0_data;
    end

    assign bus.rsp_valid = vld_q[RD_LAT-1];
    assign bus.rsp_err   = err_q[RD_LAT-1];
    assign bus.rsp_rdata = out_data;
endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: one instance with the clear sweep and
// single-cycle reads, one without the sweep and three-cycle reads.
module tb_ram_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ram_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
    ram_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus3 ();
    logic wr_err1, busy1, wr_err3, busy3;

    ram_ctrl #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(512), .RD_LAT(1),
        .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .wr_err(wr_err1), .busy(busy1)
    );

    ram_ctrl #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(512), .RD_LAT(3),
        .CLEAR_ON_RESET(1'b0), .INIT_FILE("")
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .wr_err(wr_err3), .busy(busy3)
    );

    logic        v;
    logic        e;
    logic [15:0] d;

    task automatic wr1(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be);
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b1;
        bus1.req_addr  = a;
        bus1.req_wdata = wd;
        bus1.req_be    = be;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        bus1.req_we    = 1'b0;
    endtask

    task automatic rd1(input logic [15:0] a, output logic ov, output logic oe,
                       output logic [15:0] od);
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = a;
        @(negedge clk);
        ov = bus1.rsp_valid;
        oe = bus1.rsp_err;
        od = bus1.rsp_rdata;
        bus1.req_valid = 1'b0;
    endtask

    task automatic wr3(input logic [15:0] a, input logic [15:0] wd);
        bus3.req_valid = 1'b1;
        bus3.req_we    = 1'b1;
        bus3.req_addr  = a;
        bus3.req_wdata = wd;
        bus3.req_be    = 2'b11;
        @(negedge clk);
        bus3.req_valid = 1'b0;
        bus3.req_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (bus1.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready1: got %b expected 0", bus1.req_ready);
        end
        if (busy1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy1: got %b expected 0", busy1);
        end
        if (bus1.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid1: got %b expected 0", bus1.rsp_valid);
        end
        if (bus1.rsp_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rdata1: got %h expected 0000", bus1.rsp_rdata);
        end
        if (wr_err1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_wr_err1: got %b expected 0", wr_err1);
        end
        if (bus3.req_ready !== 1'b0 || busy3 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready3: got %b/%b expected 0/0", bus3.req_ready, busy3);
        end
        if (bus3.rsp_valid !== 1'b0 || bus3.rsp_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_rsp3: got %b/%h expected 0/0000",
                     bus3.rsp_valid, bus3.rsp_rdata);
        end
    endtask

    task automatic test_clear_sweep();
        int cnt;
        int rdy_bad;
        rst_n = 1'b1;
        for (int i = 0; i < 4 && !busy1; i++) @(negedge clk);
        cnt = 0;
        rdy_bad = 0;
        // a write held on the bus during the sweep must be ignored
        bus1.req_we    = 1'b1;
        bus1.req_addr  = 16'd0;
        bus1.req_wdata = 16'hBEEF;
        bus1.req_be    = 2'b11;
        while (busy1 && cnt < 2000) begin
            bus1.req_valid = (cnt < 500);
            if (bus1.req_ready !== 1'b0) rdy_bad++;
            cnt++;
            @(negedge clk);
        end
        bus1.req_valid = 1'b0;
        bus1.req_we    = 1'b0;
        checks += 3;
        if (cnt != 512) begin
            failures++;
            $display("FAIL sweep_len: got %0d expected 512", cnt);
        end
        if (rdy_bad != 0) begin
            failures++;
            $display("FAIL sweep_ready: got %0d ready cycles expected 0", rdy_bad);
        end
        if (bus1.req_ready !== 1'b1 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL sweep_done: got ready=%b busy=%b expected 1/0",
                     bus1.req_ready, busy1);
        end
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a;
            a = (i == 0) ? 16'd0 : (i == 1) ? 16'd255 : 16'd511;
            rd1(a, v, e, d);
            checks++;
            if (v !== 1'b1 || e !== 1'b0 || d !== 16'h0000) begin
                failures++;
                $display("FAIL clear_read_%0d: got v=%b e=%b d=%h expected 1/0/0000",
                         a, v, e, d);
            end
        end
    endtask

    task automatic test_byte_enable();
        wr1(16'd5, 16'hABCD, 2'b11);
        wr1(16'd5, 16'h1234, 2'b01);
        rd1(16'd5, v, e, d);
        checks++;
        if (v !== 1'b1 || d !== 16'hAB34) begin
            failures++;
            $display("FAIL be_low: got v=%b d=%h expected 1/ab34", v, d);
        end
        wr1(16'd5, 16'hFFFF, 2'b00);
        rd1(16'd5, v, e, d);
        checks++;
        if (d !== 16'hAB34) begin
            failures++;
            $display("FAIL be_none: got %h expected ab34", d);
        end
        wr1(16'd5, 16'h5600, 2'b10);
        rd1(16'd5, v, e, d);
        checks++;
        if (d !== 16'h5634) begin
            failures++;
            $display("FAIL be_high: got %h expected 5634", d);
        end
    endtask

    task automatic test_range();
        rd1(16'd512, v, e, d);
        checks += 3;
        if (v !== 1'b1 || e !== 1'b1) begin
            failures++;
            $display("FAIL oor_read_err: got v=%b e=%b expected 1/1", v, e);
        end
        if (d !== 16'h0000) begin
            failures++;
            $display("FAIL oor_read_data: got %h expected 0000", d);
        end
        if (wr_err1 !== 1'b0) begin
            failures++;
            $display("FAIL wr_err_pre: got %b expected 0", wr_err1);
        end
        wr1(16'hFFFF, 16'h5555, 2'b11);
        checks++;
        if (wr_err1 !== 1'b1) begin
            failures++;
            $display("FAIL wr_err_set: got %b expected 1", wr_err1);
        end
        wr1(16'd512, 16'h6666, 2'b11);
        rd1(16'd511, v, e, d);
        checks++;
        if (d !== 16'h0000 || e !== 1'b0) begin
            failures++;
            $display("FAIL no_alias_511: got d=%h e=%b expected 0000/0", d, e);
        end
        rd1(16'd0, v, e, d);
        checks++;
        if (v !== 1'b1 || d !== 16'h0000 || e !== 1'b0) begin
            failures++;
            $display("FAIL no_alias_0: got v=%b d=%h e=%b expected 1/0000/0", v, d, e);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (wr_err1 !== 1'b1) begin
            failures++;
            $display("FAIL wr_err_sticky: got %b expected 1", wr_err1);
        end
    endtask

    task automatic test_latency();
        wr3(16'd0, 16'h007B);
        bus3.req_valid = 1'b1;
        bus3.req_we    = 1'b0;
        bus3.req_addr  = 16'd0;
        @(negedge clk);
        bus3.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k == 2) begin
                if (bus3.rsp_valid !== 1'b1 || bus3.rsp_rdata !== 16'h007B ||
                    bus3.rsp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL lat3_rsp: got v=%b d=%h e=%b expected 1/007b/0",
                             bus3.rsp_valid, bus3.rsp_rdata, bus3.rsp_err);
                end
            end else if (bus3.rsp_valid !== 1'b0 || bus3.rsp_rdata !== 16'h0000) begin
                failures++;
                $display("FAIL lat3_idle_%0d: got v=%b d=%h expected 0/0000",
                         k, bus3.rsp_valid, bus3.rsp_rdata);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [15:0] exp_d;
        logic        exp_v;
        for (int i = 0; i < 8; i++) wr3(16'(i), 16'h1000 + 16'(i) * 16'h0111);
        bad = 0;
        for (int k = 0; k < 13; k++) begin
            bus3.req_valid = (k < 8);
            bus3.req_we    = 1'b0;
            bus3.req_addr  = 16'(k);
            @(negedge clk);
            exp_v = (k >= 2 && k <= 9);
            exp_d = exp_v ? 16'h1000 + 16'(k - 2) * 16'h0111 : 16'h0000;
            checks++;
            if (bus3.rsp_valid !== exp_v || bus3.rsp_rdata !== exp_d) begin
                failures++;
                $display("FAIL stream_%0d: got v=%b d=%h expected %b/%h",
                         k, bus3.rsp_valid, bus3.rsp_rdata, exp_v, exp_d);
            end
        end
        bus3.req_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        int stray1;
        int stray3;
        bus3.req_valid = 1'b1;
        bus3.req_we    = 1'b0;
        bus3.req_addr  = 16'd1;
        @(negedge clk);
        bus3.req_addr  = 16'd2;
        @(negedge clk);
        // write launched on the edge that samples reset: must be dropped
        bus3.req_we    = 1'b1;
        bus3.req_addr  = 16'd3;
        bus3.req_wdata = 16'hDEAD;
        bus3.req_be    = 2'b11;
        rst_n = 1'b0;
        stray1 = 0;
        stray3 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus3.req_valid = 1'b0;
                bus3.req_we    = 1'b0;
            end
            if (k == 2) rst_n = 1'b1;
            if (bus3.rsp_valid !== 1'b0) stray3++;
            if (bus1.rsp_valid !== 1'b0) stray1++;
        end
        checks += 3;
        if (stray3 != 0 || stray1 != 0) begin
            failures++;
            $display("FAIL stray_rsp: got %0d/%0d pulses expected 0/0", stray3, stray1);
        end
        if (wr_err1 !== 1'b0) begin
            failures++;
            $display("FAIL wr_err_reset: got %b expected 0", wr_err1);
        end
        if (bus3.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready3_after_reset: got %b expected 1", bus3.req_ready);
        end
        bus3.req_valid = 1'b1;
        bus3.req_addr  = 16'd3;
        @(negedge clk);
        bus3.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus3.rsp_valid !== 1'b1 || bus3.rsp_rdata !== 16'h1333) begin
            failures++;
            $display("FAIL reset_write_drop: got v=%b d=%h expected 1/1333",
                     bus3.rsp_valid, bus3.rsp_rdata);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        for (int i = 0; i < 2000 && busy1; i++) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || bus1.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL sweep_timeout: got busy=%b ready=%b expected 0/1",
                     busy1, bus1.req_ready);
        end
        wr1(16'd400, 16'h4242, 2'b11);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4 && !busy1; i++) @(negedge clk);
        cnt = 0;
        while (busy1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || bus1.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_sweep_reset: got busy=%b ready=%b expected 0/0",
                     busy1, bus1.req_ready);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4 && !busy1; i++) @(negedge clk);
        cnt = 0;
        while (busy1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 512) begin
            failures++;
            $display("FAIL restart_sweep_len: got %0d expected 512", cnt);
        end
        rd1(16'd400, v, e, d);
        checks++;
        if (v !== 1'b1 || d !== 16'h0000) begin
            failures++;
            $display("FAIL restart_cleared: got v=%b d=%h expected 1/0000", v, d);
        end
    endtask

    initial begin
        bus1.req_valid = 1'b0;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = '0;
        bus1.req_wdata = '0;
        bus1.req_be    = '0;
        bus3.req_valid = 1'b0;
        bus3.req_we    = 1'b0;
        bus3.req_addr  = '0;
        bus3.req_wdata = '0;
        bus3.req_be    = '0;
        test_reset();
        test_clear_sweep();
        test_byte_enable();
        test_range();
        test_latency();
        test_back_to_back();
        test_reset_midstream();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
